// File: rtl/xy_divmod_unit_pkg.sv
// Shared definitions for the xy_divmod_unit divide/modulo peripheral:
// register address map, CSR bit positions and the divider FSM state encoding.
package xy_divmod_unit_pkg;

  localparam logic [2:0] ADDR_X   = 3'd0;
  localparam logic [2:0] ADDR_Y   = 3'd1;
  localparam logic [2:0] ADDR_REM = 3'd2;
  localparam logic [2:0] ADDR_QUO = 3'd3;
  localparam logic [2:0] ADDR_CSR = 3'd4;

  // CSR write fields
  localparam int CSR_START     = 0;
  localparam int CSR_SIGNED_WR = 1;
  // CSR read fields
  localparam int CSR_BUSY      = 0;
  localparam int CSR_DONE      = 1;
  localparam int CSR_DZ        = 2;
  localparam int CSR_SIGNED_RD = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_e;

endpackage

// File: rtl/xy_divmod_unit_if.sv
// Register-style bus between the processor (master) and xy_divmod_unit (slave).
//   E    block select        W/R  write/read strobes
//   ADDR register address    D    write data (DATA_W)
//   OUT  registered read data (BUS_W)
//   BUSY operation running   DONE sticky result-valid flag
interface xy_divmod_unit_if #(
  parameter int DATA_W = 16,
  parameter int BUS_W  = 32
);
  logic              E;
  logic              W;
  logic              R;
  logic [2:0]        ADDR;
  logic [DATA_W-1:0] D;
  logic [BUS_W-1:0]  OUT;
  logic              BUSY;
  logic              DONE;

  modport master (output E, W, R, ADDR, D, input OUT, BUSY, DONE);
  modport slave  (input E, W, R, ADDR, D, output OUT, BUSY, DONE);
endinterface

// File: rtl/xy_divmod_unit_core.sv
// divmod_core: multi-cycle restoring divider, one quotient bit per cycle.
//   start  launch (sampled in IDLE); operands and sgn are taken one cycle later
//   sgn    signed mode (truncating division, remainder follows dividend)
//   x, y   dividend / divisor
//   busy   FSM not idle
//   done   one-cycle pulse in FIX; rem/quo/dz are valid only while done=1
module divmod_core
  import xy_divmod_unit_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sgn,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rem,
  output logic [DATA_W-1:0] quo,
  output logic              dz
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_PREP = PREP;
  localparam logic [1:0] S_DIV  = DIV;
  localparam logic [1:0] S_FIX  = FIX;
  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] v,
                                                   input logic neg);
    return neg ? -v : v;
  endfunction

  logic [1:0]        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              neg_q_q, neg_r_q, dz_q;
  logic [DATA_W:0]   r_q;
  logic [DATA_W-1:0] q_q, b_q;

  logic              x_neg, y_neg;
  logic [DATA_W-1:0] x_mag, y_mag;
  logic [DATA_W+1:0] r_sh, diff;

  assign x_neg = sgn & x[DATA_W-1];
  assign y_neg = sgn & y[DATA_W-1];
  assign x_mag = apply_sign(x, x_neg);
  assign y_mag = apply_sign(y, y_neg);

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  assign r_sh = {r_q, q_q[DATA_W-1]};
  assign diff = r_sh - {2'b00, b_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (start) state_q <= S_PREP;
        S_PREP: begin
          cnt_q <= '0;
          if (y == '0) begin
            // Divide by zero bypasses the iteration entirely.
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            dz_q    <= 1'b1;
            state_q <= S_FIX;
          end else begin
            neg_q_q <= x_neg ^ y_neg;
            neg_r_q <= x_neg;
            dz_q    <= 1'b0;
            state_q <= S_DIV;
          end
        end
        S_DIV: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) state_q <= S_FIX;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_PREP) begin
      if (y == '0) begin
        r_q <= {1'b0, x};
        q_q <= '1;
      end else begin
        r_q <= '0;
        q_q <= x_mag;
        b_q <= y_mag;
      end
    end else if (state_q == S_DIV) begin
      if (!diff[DATA_W+1]) begin
        r_q <= diff[DATA_W:0];
        q_q <= {q_q[DATA_W-2:0], 1'b1};
      end else begin
        r_q <= r_sh[DATA_W:0];
        q_q <= {q_q[DATA_W-2:0], 1'b0};
      end
    end
  end

  // Magnitude results with signs reapplied; most-negative / -1 wraps to itself.
  assign quo  = apply_sign(q_q, neg_q_q);
  assign rem  = apply_sign(r_q[DATA_W-1:0], neg_r_q);
  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_FIX);
  assign dz   = dz_q;

endmodule

// File: rtl/xy_divmod_unit.sv
// xy_divmod_unit: memory-mapped divide/modulo peripheral (bus wrapper).
//   CLK, RST  clock (rising edge), asynchronous active-high reset
//   bus       slave side of xy_divmod_unit_if (E/W/R/ADDR/D in, OUT/BUSY/DONE out)
// Holds X, Y, SIGNED, REM, QUO, DZ, DONE and the registered read port around divmod_core.
module xy_divmod_unit
  import xy_divmod_unit_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int BUS_W      = 32,
  parameter bit AUTO_START = 1'b1
) (
  input logic         CLK,
  input logic         RST,
  xy_divmod_unit_if.slave bus
);

  logic              busy, core_done, core_dz;
  logic [DATA_W-1:0] core_rem, core_quo;
  logic              wr, start;
  logic [DATA_W-1:0] x_q, y_q, rem_q, quo_q;
  logic              sgn_q, dz_q, done_q;
  logic [BUS_W-1:0]  out_q, rd_data;

  // Register writes are only accepted while the divider is idle.
  assign wr    = bus.E & bus.W & ~busy;
  assign start = wr & (((bus.ADDR == ADDR_CSR) & bus.D[CSR_START]) |
                       ((bus.ADDR == ADDR_Y) & AUTO_START));

  divmod_core #(.DATA_W(DATA_W)) u_core (
    .clk   (CLK),
    .rst   (RST),
    .start (start),
    .sgn   (sgn_q),
    .x     (x_q),
    .y     (y_q),
    .busy  (busy),
    .done  (core_done),
    .rem   (core_rem),
    .quo   (core_quo),
    .dz    (core_dz)
  );

  always_comb begin
    rd_data = '0;
    unique case (bus.ADDR)
      ADDR_X:   rd_data[DATA_W-1:0] = x_q;
      ADDR_Y:   rd_data[DATA_W-1:0] = y_q;
      ADDR_REM: rd_data[DATA_W-1:0] = rem_q;
      ADDR_QUO: rd_data[DATA_W-1:0] = quo_q;
      ADDR_CSR: begin
        rd_data[CSR_BUSY]      = busy;
        rd_data[CSR_DONE]      = done_q;
        rd_data[CSR_DZ]        = dz_q;
        rd_data[CSR_SIGNED_RD] = sgn_q;
      end
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      x_q    <= '0;
      y_q    <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      sgn_q  <= 1'b0;
      dz_q   <= 1'b0;
      done_q <= 1'b0;
      out_q  <= '0;
    end else begin
      if (wr && bus.ADDR == ADDR_X)   x_q   <= bus.D;
      if (wr && bus.ADDR == ADDR_Y)   y_q   <= bus.D;
      if (wr && bus.ADDR == ADDR_CSR) sgn_q <= bus.D[CSR_SIGNED_WR];
      if (start) begin
        done_q <= 1'b0;
        dz_q   <= 1'b0;
      end else if (core_done) begin
        done_q <= 1'b1;
        dz_q   <= core_dz;
        rem_q  <= core_rem;
        quo_q  <= core_quo;
      end
      // Read mux sees pre-edge register values, so a same-edge write returns old data.
      if (bus.E && bus.R) out_q <= rd_data;
    end
  end

  assign bus.OUT  = out_q;
  assign bus.BUSY = busy;
  assign bus.DONE = done_q;

endmodule

// File: tb/tb_xy_divmod_unit.sv
module tb_xy_divmod_unit;

  logic CLK = 1'b0;
  logic RST;
  int   errors = 0;
  int   checks = 0;

  xy_divmod_unit_if #(.DATA_W(16), .BUS_W(32)) bus();

  xy_divmod_unit #(.DATA_W(16), .BUS_W(32), .AUTO_START(1'b1)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    bus.E = 1'b1; bus.W = 1'b1; bus.R = 1'b0; bus.ADDR = a; bus.D = d;
    @(posedge CLK); #1;
    bus.E = 1'b0; bus.W = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] v);
    bus.E = 1'b1; bus.R = 1'b1; bus.W = 1'b0; bus.ADDR = a;
    @(posedge CLK); #1;
    bus.E = 1'b0; bus.R = 1'b0;
    v = bus.OUT;
  endtask

  // Counts clock edges until BUSY drops; -1 if it never does.
  task automatic wait_idle(output int n);
    n = 0;
    while (bus.BUSY === 1'b1 && n < 200) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n >= 200) n = -1;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    checks++; if (bus.OUT !== 32'h0) begin errors++; $display("FAIL reset_out got=%h exp=%h", bus.OUT, 32'h0); end
    checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.BUSY); end
    checks++; if (bus.DONE !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.DONE); end
    RST = 1'b0;
    bus_read(3'd0, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_x got=%h exp=%h", v, 32'h0); end
    bus_read(3'd4, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_status got=%h exp=%h", v, 32'h0); end
  endtask

  task automatic test_unsigned;
    logic [31:0] v; int n;
    bus_write(3'd0, 16'd100);
    bus_write(3'd1, 16'd7);
    checks++; if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL uns_busy got=%b exp=1", bus.BUSY); end
    wait_idle(n);
    checks++; if (n !== 18) begin errors++; $display("FAIL uns_latency got=%0d exp=18", n); end
    checks++; if (bus.DONE !== 1'b1) begin errors++; $display("FAIL uns_done got=%b exp=1", bus.DONE); end
    bus_read(3'd2, v);
    checks++; if (v !== 32'h00000002) begin errors++; $display("FAIL uns_rem got=%h exp=%h", v, 32'h2); end
    bus_read(3'd3, v);
    checks++; if (v !== 32'd14) begin errors++; $display("FAIL uns_quo got=%h exp=%h", v, 32'd14); end
  endtask

  task automatic test_signed;
    logic [31:0] v; int n;
    bus_write(3'd0, 16'hFFF9);
    bus_write(3'd1, 16'd2);       // auto-starts unsigned; let it finish
    wait_idle(n);
    bus_write(3'd4, 16'h0003);
    wait_idle(n);
    checks++; if (n !== 18) begin errors++; $display("FAIL sgn_latency got=%0d exp=18", n); end
    bus_read(3'd3, v);
    checks++; if (v !== 32'h0000FFFD) begin errors++; $display("FAIL sgn_quo1 got=%h exp=%h", v, 32'hFFFD); end
    bus_read(3'd2, v);
    checks++; if (v !== 32'h0000FFFF) begin errors++; $display("FAIL sgn_rem1 got=%h exp=%h", v, 32'hFFFF); end
    bus_write(3'd0, 16'd7);
    bus_write(3'd1, 16'hFFFE);    // SIGNED still 1
    wait_idle(n);
    bus_read(3'd3, v);
    checks++; if (v !== 32'h0000FFFD) begin errors++; $display("FAIL sgn_quo2 got=%h exp=%h", v, 32'hFFFD); end
    bus_read(3'd2, v);
    checks++; if (v !== 32'h00000001) begin errors++; $display("FAIL sgn_rem2 got=%h exp=%h", v, 32'h1); end
    bus_read(3'd4, v);
    checks++; if (v !== 32'hA) begin errors++; $display("FAIL sgn_status got=%h exp=%h", v, 32'hA); end
  endtask

  task automatic test_div_zero;
    logic [31:0] v; int n;
    bus_write(3'd4, 16'h0000);
    bus_write(3'd0, 16'h1234);
    bus_write(3'd1, 16'h0000);
    wait_idle(n);
    checks++; if (n !== 2) begin errors++; $display("FAIL dz_latency got=%0d exp=2", n); end
    bus_read(3'd4, v);
    checks++; if (v !== 32'h6) begin errors++; $display("FAIL dz_status_uns got=%h exp=%h", v, 32'h6); end
    bus_read(3'd3, v);
    checks++; if (v !== 32'h0000FFFF) begin errors++; $display("FAIL dz_quo got=%h exp=%h", v, 32'hFFFF); end
    bus_read(3'd2, v);
    checks++; if (v !== 32'h00001234) begin errors++; $display("FAIL dz_rem got=%h exp=%h", v, 32'h1234); end
    bus_write(3'd4, 16'h0003);
    wait_idle(n);
    checks++; if (n !== 2) begin errors++; $display("FAIL dz_latency_sgn got=%0d exp=2", n); end
    bus_read(3'd4, v);
    checks++; if (v !== 32'hE) begin errors++; $display("FAIL dz_status_sgn got=%h exp=%h", v, 32'hE); end
  endtask

  task automatic test_overflow;
    logic [31:0] v; int n;
    bus_write(3'd0, 16'h8000);
    bus_write(3'd1, 16'hFFFF);    // signed mode retained
    wait_idle(n);
    checks++; if (n !== 18) begin errors++; $display("FAIL ovf_latency got=%0d exp=18", n); end
    bus_read(3'd3, v);
    checks++; if (v !== 32'h00008000) begin errors++; $display("FAIL ovf_quo got=%h exp=%h", v, 32'h8000); end
    bus_read(3'd2, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL ovf_rem got=%h exp=%h", v, 32'h0); end
    bus_read(3'd4, v);
    checks++; if (v !== 32'hA) begin errors++; $display("FAIL ovf_status got=%h exp=%h", v, 32'hA); end
  endtask

  task automatic test_busy_lockout;
    logic [31:0] v; int n;
    bus_write(3'd4, 16'h0000);
    bus_write(3'd0, 16'd100);
    bus_write(3'd1, 16'd7);
    bus_write(3'd0, 16'd5);
    bus_write(3'd4, 16'h0001);
    bus_read(3'd4, v);
    checks++; if (v !== 32'h1) begin errors++; $display("FAIL busy_status got=%h exp=%h", v, 32'h1); end
    bus_read(3'd2, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL busy_prior_rem got=%h exp=%h", v, 32'h0); end
    wait_idle(n);
    checks++; if (n < 0) begin errors++; $display("FAIL busy_timeout got=%0d exp>=0", n); end
    bus_read(3'd0, v);
    checks++; if (v !== 32'd100) begin errors++; $display("FAIL busy_x_kept got=%h exp=%h", v, 32'd100); end
    bus_read(3'd2, v);
    checks++; if (v !== 32'd2) begin errors++; $display("FAIL busy_final_rem got=%h exp=%h", v, 32'd2); end
    bus_read(3'd4, v);
    checks++; if (v !== 32'h2) begin errors++; $display("FAIL busy_final_status got=%h exp=%h", v, 32'h2); end
  endtask

  task automatic test_abort_and_misc;
    logic [31:0] v; int n;
    bus_write(3'd1, 16'd7);
    repeat (7) @(posedge CLK);
    #1 RST = 1'b1;
    #1;
    checks++; if (bus.OUT !== 32'h0) begin errors++; $display("FAIL abort_out got=%h exp=%h", bus.OUT, 32'h0); end
    checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", bus.BUSY); end
    @(posedge CLK); #1 RST = 1'b0;
    bus_read(3'd2, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL abort_rem got=%h exp=%h", v, 32'h0); end
    bus_read(3'd3, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL abort_quo got=%h exp=%h", v, 32'h0); end
    bus_read(3'd4, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL abort_status got=%h exp=%h", v, 32'h0); end
    repeat (20) @(posedge CLK);
    #1;
    checks++; if (bus.DONE !== 1'b0) begin errors++; $display("FAIL abort_no_done got=%b exp=0", bus.DONE); end
    // Write strobe without block select must be ignored.
    bus.E = 1'b0; bus.W = 1'b1; bus.ADDR = 3'd0; bus.D = 16'h00AA;
    @(posedge CLK); #1 bus.W = 1'b0;
    bus_read(3'd0, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL e0_write got=%h exp=%h", v, 32'h0); end
    bus_write(3'd0, 16'd9);
    bus_write(3'd1, 16'd4);
    wait_idle(n);
    checks++; if (n !== 18) begin errors++; $display("FAIL post_latency got=%0d exp=18", n); end
    bus_read(3'd2, v);
    checks++; if (v !== 32'd1) begin errors++; $display("FAIL post_rem got=%h exp=%h", v, 32'd1); end
    bus_read(3'd3, v);
    checks++; if (v !== 32'd2) begin errors++; $display("FAIL post_quo got=%h exp=%h", v, 32'd2); end
    // Same-edge read and write: old value returned, new value stored.
    bus.E = 1'b1; bus.R = 1'b1; bus.W = 1'b1; bus.ADDR = 3'd0; bus.D = 16'h0055;
    @(posedge CLK); #1;
    bus.E = 1'b0; bus.R = 1'b0; bus.W = 1'b0;
    checks++; if (bus.OUT !== 32'd9) begin errors++; $display("FAIL rw_old got=%h exp=%h", bus.OUT, 32'd9); end
    bus_read(3'd0, v);
    checks++; if (v !== 32'h55) begin errors++; $display("FAIL rw_new got=%h exp=%h", v, 32'h55); end
    bus_write(3'd5, 16'hFFFF);
    bus_read(3'd5, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL addr5 got=%h exp=%h", v, 32'h0); end
  endtask

  initial begin
    RST = 1'b1;
    bus.E = 1'b0; bus.W = 1'b0; bus.R = 1'b0; bus.ADDR = 3'd0; bus.D = 16'h0;
    repeat (3) @(posedge CLK);
    #1;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_busy_lockout();
    test_abort_and_misc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xy_divmod_unit.md
Name: xy_divmod_unit

Overview:
- Parametrised, memory-mapped integer divide/modulo peripheral on the processor's register-style bus.
- Software writes operands X and Y and gets both remainder and quotient. Signed or unsigned mode is selected per operation.
- Replaces the fixed 16-bit combinational modulo unit with a multi-cycle restoring divider. It adds BUSY/DONE status and divide-by-zero handling.

Parameters:
DATA_W, 16, operand/result width (>= 2)
BUS_W, 32, read-data width; results zero-extended; must be >= DATA_W
AUTO_START, 1, 1 = a write to Y also launches an operation

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous, active-high reset
E  input  1  block select; R and W are ignored when E=0
W  input  1  write strobe
R  input  1  read strobe
ADDR  input  3  register address
D  input  DATA_W  write data
OUT  output  BUS_W  registered read data
BUSY  output  1  operation in progress
DONE  output  1  result valid; sticky until the next start

Behaviour:
- Address map:
  - 0 X (R/W)
  - 1 Y (R/W)
  - 2 REM (RO)
  - 3 QUO (RO)
  - 4 CTRL/STATUS. Write: bit0 START, bit1 SIGNED. Read: bit0 BUSY, bit1 DONE, bit2 DZ, bit3 SIGNED.
  - 5-7 read 0; writes ignored.
- Reset (RST=1, asynchronous):
  - X, Y, REM, QUO, SIGNED, DZ, OUT, BUSY, DONE all go to 0; FSM goes to IDLE.
  - Assertion mid-operation aborts the operation. No DONE follows.
- Read: on the edge where E&R, OUT <= addressed value zero-extended to BUS_W. 1-cycle latency. OUT holds otherwise.
- Same-edge R&W to one address: the write takes effect and OUT returns the old value.
- Start conditions: edge t with E&W, in IDLE, and either:
  - ADDR=4 with D[0]=1, or
  - ADDR=1 with AUTO_START=1 (Y updated the same edge; SIGNED keeps its last value).
- At start: DONE <= 0, DZ <= 0, BUSY <= 1.
- FSM sequence:
  - IDLE -> PREP (1 cycle): capture operands; in signed mode take magnitudes and record the sign of the quotient and of the remainder.
  - PREP -> DIV for DATA_W cycles: one restoring shift-subtract step per cycle.
  - DIV -> FIX (1 cycle): apply the signs and write REM/QUO.
  - FIX -> IDLE.
- Latency: REM/QUO update, BUSY=0 and DONE=1 occur at edge t+DATA_W+2, in both modes.
- Signed semantics: truncating division; remainder sign follows the dividend.
- Divide by zero (Y==0, detected in PREP):
  - Skip DIV and go to FIX.
  - QUO = all ones, REM = X, DZ = 1.
  - DONE at edge t+2.
- Signed overflow (X = most negative, Y = -1): QUO = X, REM = 0, DZ = 0. Normal latency.
- While BUSY:
  - Writes to X, Y and CTRL are dropped, including START.
  - Reads are allowed; REM/QUO return the previous result until FIX.
- Operand widths: internal remainder register is DATA_W+1 bits; there is no truncation before FIX.

Decomposition:
- Shared package holds:
  - address constants ADDR_X, ADDR_Y, ADDR_REM, ADDR_QUO, ADDR_CSR
  - CSR bit indices
  - FSM state enum {IDLE, PREP, DIV, FIX}
- One natural sub-module, divmod_core (FSM plus datapath):
  - Inputs: start, signed, x, y.
  - Outputs: busy, done pulse, rem, quo, dz.
  - xy_divmod_unit is the register/bus wrapper around it.

Test Plan:
1. DATA_W=16, unsigned: X=100, Y=7 via auto-start -> BUSY for 18 cycles; then REM=2, QUO=14, DONE=1. Read ADDR 2 gives OUT=0x00000002 one cycle later.
2. Signed: X=0xFFF9 (-7), Y=2, CTRL=0x3 -> QUO=0xFFFD (-3), REM=0xFFFF (-1). Repeat with X=7, Y=0xFFFE (-2) -> QUO=0xFFFD, REM=0x0001.
3. Y=0, X=0x1234 -> DZ=1, QUO=0xFFFF, REM=0x1234, DONE at t+2. STATUS read returns 0x6 in unsigned mode, 0xE in signed mode.
4. Signed overflow: X=0x8000, Y=0xFFFF -> QUO=0x8000, REM=0, DZ=0, latency 18.
5. Start 100/7, then write X=5 and START during BUSY -> both ignored; STATUS reads BUSY=1; REM read mid-op returns the prior result; final REM=2.
6. Assert RST at cycle t+8 of an operation -> OUT, REM, QUO, STATUS immediately 0; no DONE afterwards. A subsequent 9/4 operation returns REM=1, QUO=2. E=0 with W=1 leaves X unchanged.
